// File: rtl/riscv_imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian bytes into 32-bit words,
// writes them to consecutive word addresses and holds the core in reset while loading.
module riscv_imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] len_words,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [11:0] DEPTH_L = 12'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [10:0] r_word_idx;
    logic [10:0] r_len;
    logic [31:0] r_wd;
    logic        r_err;
    logic        r_cpu_rst_n;

    logic w_idle_like;
    logic w_len_ok;
    logic w_accept;
    logic w_reject;
    logic w_busy;
    logic w_abort;
    logic w_hs;
    logic w_last;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_len_ok    = (len_words != 11'd0) && ({1'b0, len_words} <= DEPTH_L);
    assign w_accept    = w_idle_like && start && w_len_ok;
    assign w_reject    = w_idle_like && start && !w_len_ok;
    assign w_busy      = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign w_abort     = w_busy && abort;
    assign w_hs        = byte_valid && byte_ready;
    assign w_last      = (r_word_idx == r_len - 11'd1);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (w_accept) w_next = S_COLLECT;
            S_COLLECT: begin
                if (abort)                            w_next = S_IDLE;
                else if (w_hs && r_byte_cnt == 2'd3) w_next = S_COLLECT == S_COLLECT ? S_WRITE : S_WRITE;
            end
            S_WRITE: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_COLLECT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= 2'd0;
            r_word_idx  <= 11'd0;
            r_len       <= 11'd0;
            r_wd        <= 32'd0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            // Registered from the next state so the core reset is glitch-free and aligned with busy.
            r_cpu_rst_n <= !((w_next == S_COLLECT) || (w_next == S_WRITE));

            if (w_accept) begin
                r_byte_cnt <= 2'd0;
                r_word_idx <= 11'd0;
                r_len      <= len_words;
                r_err      <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end

            if (w_abort) begin
                r_byte_cnt <= 2'd0;
            end else if (w_hs) begin
                r_wd[{r_byte_cnt, 3'b000} +: 8] <= byte_data;
                r_byte_cnt                      <= r_byte_cnt + 2'd1;
            end

            if ((r_state == S_WRITE) && !abort && !w_last)
                r_word_idx <= r_word_idx + 11'd1;
        end
    end

    // The write strobe is suppressed combinationally so an abort in WRITE never reaches memory.
    assign we         = (r_state == S_WRITE) && !abort;
    assign wa         = we ? (BASE_ADDR + {19'd0, r_word_idx, 2'b00}) : 32'd0;
    assign wd         = r_wd;
    assign byte_ready = (r_state == S_COLLECT);
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign cpu_rst_n  = r_cpu_rst_n;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed self-checking bench for riscv_imem_loader; a negedge monitor logs every write.
module tb_riscv_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] len_words;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_wa[$];
    logic [31:0] q_wd[$];

    riscv_imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            q_wa.push_back(wa);
            q_wd.push_back(wd);
        end
    end

    task automatic clear_log();
        q_wa.delete();
        q_wd.delete();
    endtask

    task automatic do_start(input logic [10:0] len);
        start     = 1'b1;
        len_words = len;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Leaves byte_valid high on return so consecutive calls give a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        logic got;
        int   n;
        got        = 1'b0;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!got && n < 20) begin
            @(negedge clk);
            if (byte_ready === 1'b1) got = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len_words = 11'd0; abort = 1'b0;
        byte_valid = 1'b0; byte_data = 8'd0;
        #1;
        checks++;
        if ({byte_ready, we, busy, done, err, cpu_rst_n} !== 6'b0 || wa !== 32'd0 || wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/we/busy/done/err/cpu=%b wa=%h wd=%h, want all zero",
                     {byte_ready, we, busy, done, err, cpu_rst_n}, wa, wd);
        end
        #21;
        checks++;
        if (cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL reset_cpu_held: cpu_rst_n=%b want 0", cpu_rst_n);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cpu_rst_n !== 1'b1) begin
            errors++; $display("FAIL reset_release_cpu: cpu_rst_n=%b want 1", cpu_rst_n);
        end
    endtask

    task automatic test_two_words();
        clear_log();
        do_start(11'd2);
        checks++;
        if (busy !== 1'b1 || cpu_rst_n !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: busy=%b cpu_rst_n=%b rdy=%b want 1 0 1", busy, cpu_rst_n, byte_ready);
        end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (we !== 1'b1 || wa !== 32'h0 || wd !== 32'h0000_0013 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: we=%b wa=%h wd=%h rdy=%b want 1 0 00000013 0", we, wa, wd, byte_ready);
        end
        send_byte(8'hB3); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        byte_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q_wa.size() != 2) begin
            errors++; $display("FAIL two_word_count: writes=%0d want 2", q_wa.size());
        end else if (q_wa[0] !== 32'h0 || q_wd[0] !== 32'h0000_0013 ||
                     q_wa[1] !== 32'h4 || q_wd[1] !== 32'h0050_00B3) begin
            errors++;
            $display("FAIL two_word_data: (%h,%h) (%h,%h) want (0,00000013) (4,005000b3)",
                     q_wa[0], q_wd[0], q_wa[1], q_wd[1]);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_rst_n !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL two_word_end: done=%b busy=%b cpu=%b err=%b want 1 0 1 0", done, busy, cpu_rst_n, err);
        end
    endtask

    task automatic test_bad_len();
        clear_log();
        do_start(11'd0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL len_zero: err=%b busy=%b rdy=%b done=%b want 1 0 0 1", err, busy, byte_ready, done);
        end
        do_start(11'd1025);
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b1 || q_wa.size() != 0) begin
            errors++;
            $display("FAIL len_1025: err=%b busy=%b rdy=%b done=%b writes=%0d want 1 0 0 1 0",
                     err, busy, byte_ready, done, q_wa.size());
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] bytes[4];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        do_start(11'd1);
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL accept_clears: err=%b done=%b want 0 0", err, done);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            byte_valid = 1'b0;
            if (i == 1) begin
                start = 1'b1; len_words = 11'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (q_wa.size() != 1 || q_wa[0] !== 32'h0 || q_wd[0] !== 32'hDDCC_BBAA || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_write: writes=%0d wa=%h wd=%h done=%b want 1 0 ddccbbaa 1",
                     q_wa.size(), (q_wa.size() > 0) ? q_wa[0] : 32'hx, (q_wd.size() > 0) ? q_wd[0] : 32'hx, done);
        end
    endtask

    task automatic test_abort();
        clear_log();
        do_start(11'd3);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        byte_valid = 1'b0;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cpu_rst_n !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b cpu=%b rdy=%b want 0 0 1 0", busy, done, cpu_rst_n, byte_ready);
        end
        checks++;
        if (q_wa.size() != 1 || q_wa[0] !== 32'h0 || q_wd[0] !== 32'h1312_1110) begin
            errors++; $display("FAIL abort_writes: writes=%0d want 1 at wa 0 wd 13121110", q_wa.size());
        end
        clear_log();
        do_start(11'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        byte_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q_wa.size() != 1 || q_wa[0] !== 32'h0 || q_wd[0] !== 32'h0403_0201) begin
            errors++;
            $display("FAIL restart_after_abort: writes=%0d wa=%h wd=%h want 1 0 04030201",
                     q_wa.size(), (q_wa.size() > 0) ? q_wa[0] : 32'hx, (q_wd.size() > 0) ? q_wd[0] : 32'hx);
        end
    endtask

    task automatic test_abort_in_write();
        clear_log();
        do_start(11'd2);
        send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE);
        byte_valid = 1'b0;
        abort      = 1'b1;
        start      = 1'b1;
        len_words  = 11'd1;
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL abort_write_strobe: we=%b want 0", we);
        end
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q_wa.size() != 0) begin
            errors++;
            $display("FAIL abort_in_write: busy=%b done=%b writes=%0d want 0 0 0", busy, done, q_wa.size());
        end
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        do_start(11'd2);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        #2;
        rst_n = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if ({byte_ready, we, busy, done, err, cpu_rst_n} !== 6'b0 || wa !== 32'd0 || wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_write: rdy/we/busy/done/err/cpu=%b wa=%h wd=%h want all zero",
                     {byte_ready, we, busy, done, err, cpu_rst_n}, wa, wd);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (q_wa.size() != 0 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write_after: writes=%0d cpu=%b busy=%b want 0 1 0", q_wa.size(), cpu_rst_n, busy);
        end
    endtask

    task automatic test_full_depth();
        int          bad;
        logic [31:0] exp_wd;
        clear_log();
        do_start(11'd1024);
        for (int i = 0; i < 4096; i++) send_byte(8'(i));
        byte_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q_wa.size() != 1024 || done !== 1'b1) begin
            errors++; $display("FAIL full_count: writes=%0d done=%b want 1024 1", q_wa.size(), done);
        end
        checks++;
        if (q_wa.size() == 0 || q_wa[q_wa.size()-1] !== 32'h0000_0FFC) begin
            errors++;
            $display("FAIL full_last_addr: wa=%h want 00000ffc", (q_wa.size() > 0) ? q_wa[q_wa.size()-1] : 32'hx);
        end
        bad = 0;
        for (int k = 0; k < q_wa.size(); k++) begin
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = 8'(4*k + j);
            if (q_wa[k] !== 32'(4*k) || q_wd[k] !== exp_wd) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL full_sequence: %0d writes with wrong address or data, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_bad_len();
        test_toggle_valid();
        test_abort();
        test_abort_in_write();
        test_reset_mid_write();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_imem_loader.md
RISCV_IMEM_LOADER -- requirements
Module: riscv_imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning a pulse that begins a load.
REQ-006 SHALL have port len_words  input  11  meaning the number of words to load, sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  meaning cancel of the load in progress.
REQ-008 SHALL have port byte_valid  input  1  meaning byte_data is valid.
REQ-009 SHALL have port byte_data  input  8  meaning one program byte, in little-endian order within each word.
REQ-010 SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-011 SHALL have port we  output  1  meaning the instruction-memory write strobe.
REQ-012 SHALL have port wa  output  32  meaning the word-aligned byte write address.
REQ-013 SHALL have port wd  output  32  meaning the write data word.
REQ-014 SHALL have port busy  output  1  meaning a load is in progress.
REQ-015 SHALL have port done  output  1  meaning the last load completed.
REQ-016 SHALL have port err  output  1  meaning the last start was rejected.
REQ-017 SHALL have port cpu_rst_n  output  1  meaning the active-low core reset, held asserted while loading.

Function
REQ-018 SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-019 Byte handshake SHALL occur only when byte_valid and byte_ready are both 1 in the same cycle; byte_ready SHALL be 1 only in COLLECT.
REQ-020 IDLE/DONE + start: SHALL go to COLLECT if 1 <= len_words <= DEPTH; this clears done, clears err and zeroes the byte and word counters.
REQ-021 IDLE/DONE + start with len_words = 0 or len_words > DEPTH: SHALL stay in the current state, set err=1 and leave done unchanged.
REQ-022 start while busy SHALL be ignored.
REQ-023 COLLECT: handshake byte k (k = 0..3) SHALL be placed in wd_reg[8k+7:8k]; the byte counter SHALL wrap 3 -> 0.
REQ-024 COLLECT: after the 4th byte is accepted, SHALL go to WRITE on the next edge.
REQ-025 WRITE: SHALL hold for exactly one cycle with we=1, wa = BASE_ADDR + 4*word_idx, wd = assembled word; byte_ready=0 during this cycle.
REQ-026 WRITE: if word_idx = len-1, SHALL go to DONE, otherwise increment word_idx and go to COLLECT.
REQ-027 Latency SHALL be 1 cycle from acceptance of the 4th byte to we=1; maximum throughput is 4 bytes per 5 cycles.
REQ-028 DONE: done SHALL be 1 and held until the next accepted start, reset, or abort.
REQ-029 busy SHALL be 1 in COLLECT and WRITE only.
REQ-030 cpu_rst_n SHALL be 0 in COLLECT and WRITE and 1 otherwise; it SHALL be driven registered and glitch-free.
REQ-031 abort in COLLECT or WRITE SHALL return to IDLE on the next edge, with no write in that cycle even if it is in WRITE.
REQ-032 abort SHALL discard partial bytes, leave done=0, and be ignored in IDLE and DONE.
REQ-033 abort and start in the same cycle: abort SHALL win when busy; start SHALL be processed when idle.
REQ-034 wa[1:0] SHALL always be 2'b00; wa SHALL never exceed BASE_ADDR + 4*(DEPTH-1).
REQ-035 we SHALL be 0 in every state except WRITE.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE: byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, cpu_rst_n=0, with all counters zero.
REQ-037 On rst_n release, cpu_rst_n SHALL rise to 1 at the first clock edge.
REQ-038 Reset asserted mid-load SHALL abandon the load with no further writes.

Verification
REQ-039 start with len_words=2, bytes 13 00 00 00 B3 00 50 00 with continuous valid -> we pulses twice: (wa=0x0, wd=0x00000013), then (wa=0x4, wd=0x005000B3); done=1; cpu_rst_n returns to 1.
REQ-040 start with len_words=0, then with len_words=1025 -> err=1, busy stays 0, no byte_ready, no we.
REQ-041 len_words=1 with byte_valid toggling on alternate cycles -> exactly one write with the correct word; byte_ready drops during WRITE and no byte is lost or duplicated.
REQ-042 abort after 6 bytes of a len_words=3 load -> exactly one write (wa=0x0), then IDLE with done=0; a new start restarts at wa=0x0 with the byte counter at 0.
REQ-043 rst_n pulsed low asynchronously mid-WRITE -> we=0 immediately and all outputs at reset values; no write completes.
REQ-044 len_words=1024 full load -> the last write has wa=0xFFC, 1024 we pulses in total, and done=1.
